// File: rtl/mem_write_checker.sv
// In-order store checker: an expected-write FIFO is armed in IDLE, then each CPU
// store in RUN must match the head, fall in the ignore window, or the run fails.
module mem_write_checker #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 32,
  parameter int DEPTH   = 8,
  parameter int IGN_LO  = 80,
  parameter int IGN_HI  = 80,
  parameter int TIMEOUT = 100000
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic                     exp_valid,
  output logic                     exp_ready,
  input  logic [ADDR_W-1:0]        exp_addr,
  input  logic [DATA_W-1:0]        exp_data,
  input  logic                     memwrite,
  input  logic [ADDR_W-1:0]        dataadr,
  input  logic [DATA_W-1:0]        writedata,
  output logic                     pass,
  output logic                     fail,
  output logic                     timeout,
  output logic                     done,
  output logic [$clog2(DEPTH):0]   match_cnt,
  output logic [ADDR_W-1:0]        err_addr,
  output logic [DATA_W-1:0]        err_data,
  output logic [31:0]              cycle_cnt
);
  localparam int PW = $clog2(DEPTH);

  typedef enum logic [2:0] {S_IDLE, S_RUN, S_PASS, S_FAIL, S_TMO} state_t;
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } entry_t;

  state_t state, state_nx;
  entry_t q [DEPTH];
  entry_t head;
  logic [PW:0] wr_ptr, rd_ptr, count;
  logic full, empty, last, push, pop, flush, hit, in_ign;

  assign count     = wr_ptr - rd_ptr;
  assign empty     = (wr_ptr == rd_ptr);
  assign full      = (count == (PW+1)'(DEPTH));
  assign last      = (count == (PW+1)'(1));
  assign head      = q[rd_ptr[PW-1:0]];
  assign exp_ready = (state == S_IDLE) && !full;
  assign push      = exp_valid && exp_ready;
  assign hit       = (dataadr == head.addr) && (writedata == head.data);
  assign in_ign    = (dataadr >= ADDR_W'(IGN_LO)) && (dataadr <= ADDR_W'(IGN_HI));
  assign done      = pass | fail | timeout;

  always_comb begin
    state_nx = state;
    pop      = 1'b0;
    flush    = 1'b0;
    unique case (state)
      S_IDLE:
        if (start) state_nx = (empty && !push) ? S_PASS : S_RUN;
      S_RUN: begin
        if (memwrite && hit) begin
          pop = 1'b1;
          if (last) state_nx = S_PASS;
        end else if (memwrite && !in_ign) begin
          state_nx = S_FAIL;
        end
        // A completing match or a fail in the last budget cycle outranks the timeout
        if (state_nx == S_RUN && cycle_cnt == 32'(TIMEOUT - 1)) state_nx = S_TMO;
      end
      default:
        if (start) begin
          state_nx = S_IDLE;
          flush    = 1'b1;
        end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= S_IDLE;
      pass    <= 1'b0;
      fail    <= 1'b0;
      timeout <= 1'b0;
    end else begin
      state   <= state_nx;
      pass    <= (state_nx == S_PASS);
      fail    <= (state_nx == S_FAIL);
      timeout <= (state_nx == S_TMO);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk)
    if (push) q[wr_ptr[PW-1:0]] <= '{addr: exp_addr, data: exp_data};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      match_cnt <= '0;
      cycle_cnt <= '0;
      err_addr  <= '0;
      err_data  <= '0;
    end else if (flush || (state == S_IDLE && start)) begin
      match_cnt <= '0;
      cycle_cnt <= '0;
      err_addr  <= '0;
      err_data  <= '0;
    end else if (state == S_RUN) begin
      if (pop) match_cnt <= match_cnt + 1'b1;
      // Counter freezes on the exit cycle so it reports the deciding cycle
      if (state_nx == S_RUN && cycle_cnt != '1) cycle_cnt <= cycle_cnt + 1'b1;
      if (state_nx == S_FAIL) begin
        err_addr <= dataadr;
        err_data <= writedata;
      end
    end
  end
endmodule

// File: tb/tb_mem_write_checker.sv
// Directed bench for mem_write_checker with hand-computed expectations.
module tb_mem_write_checker;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0, exp_valid = 1'b0, memwrite = 1'b0;
  logic        exp_ready, pass, fail, timeout, done;
  logic [31:0] exp_addr = '0, dataadr = '0, cycle_cnt, err_addr;
  logic [31:0] exp_data = '0, writedata = '0, err_data;
  logic [3:0]  match_cnt;
  int checks = 0, errors = 0;

  mem_write_checker #(.DATA_W(32), .ADDR_W(32), .DEPTH(8), .IGN_LO(80), .IGN_HI(80),
                      .TIMEOUT(20)) dut (
    .clk(clk), .reset(reset), .start(start), .exp_valid(exp_valid), .exp_ready(exp_ready),
    .exp_addr(exp_addr), .exp_data(exp_data), .memwrite(memwrite), .dataadr(dataadr),
    .writedata(writedata), .pass(pass), .fail(fail), .timeout(timeout), .done(done),
    .match_cnt(match_cnt), .err_addr(err_addr), .err_data(err_data), .cycle_cnt(cycle_cnt));

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    reset = 1'b0; #2; reset = 1'b1; tick();
  endtask

  task automatic push(input logic [31:0] a, input logic [31:0] d);
    exp_valid = 1'b1; exp_addr = a; exp_data = d; tick(); exp_valid = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1; tick(); start = 1'b0;
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d);
    memwrite = 1'b1; dataadr = a; writedata = d; tick(); memwrite = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0; #1;
    checks++; if ({pass, fail, timeout, done} !== 4'b0) begin errors++;
      $display("FAIL reset_flags got %b want 0000", {pass, fail, timeout, done}); end
    checks++; if (exp_ready !== 1'b1) begin errors++;
      $display("FAIL reset_ready got %b want 1", exp_ready); end
    checks++; if ({match_cnt, err_addr, err_data, cycle_cnt} !== '0) begin errors++;
      $display("FAIL reset_counts got %0d %0d %0d %0d want 0", match_cnt, err_addr, err_data, cycle_cnt); end
    reset = 1'b1; tick();
  endtask

  task automatic test_ignore_then_match();
    do_reset(); push(84, 7); pulse_start();
    store(80, 3);
    checks++; if ({pass, fail} !== 2'b00) begin errors++;
      $display("FAIL ignore_store got pass=%b fail=%b want 0 0", pass, fail); end
    store(84, 7);
    checks++; if ({pass, fail, done} !== 3'b101 || match_cnt !== 4'd1) begin errors++;
      $display("FAIL match_pass got pass=%b fail=%b done=%b cnt=%0d want 1 0 1 1", pass, fail, done, match_cnt); end
    tick();
    checks++; if (pass !== 1'b1) begin errors++;
      $display("FAIL pass_sticky got %b want 1", pass); end
  endtask

  task automatic test_bad_store();
    do_reset(); push(84, 7); pulse_start(); store(88, 5);
    checks++; if ({fail, pass} !== 2'b10 || err_addr !== 32'd88 || err_data !== 32'd5) begin errors++;
      $display("FAIL bad_addr got fail=%b pass=%b ea=%0d ed=%0d want 1 0 88 5", fail, pass, err_addr, err_data); end
    do_reset(); push(84, 7); pulse_start(); store(84, 6);
    checks++; if (fail !== 1'b1 || err_data !== 32'd6 || err_addr !== 32'd84) begin errors++;
      $display("FAIL bad_data got fail=%b ea=%0d ed=%0d want 1 84 6", fail, err_addr, err_data); end
  endtask

  task automatic fill8(input bit try_ninth);
    for (int i = 0; i < 9; i++) begin
      if (i == 8 && !try_ninth) break;
      if (i == 8) begin
        checks++; if (exp_ready !== 1'b0) begin errors++;
          $display("FAIL full_ready got %b want 0", exp_ready); end
      end
      push(32'(100 + 4*i), 32'(i + 1));
    end
  endtask

  task automatic test_full_fifo();
    do_reset(); fill8(1'b1); pulse_start();
    for (int i = 0; i < 8; i++) begin
      if (i == 7) begin
        checks++; if (pass !== 1'b0) begin errors++;
          $display("FAIL early_pass got %b want 0", pass); end
      end
      store(32'(100 + 4*i), 32'(i + 1));
    end
    checks++; if (pass !== 1'b1 || match_cnt !== 4'd8 || fail !== 1'b0) begin errors++;
      $display("FAIL full_pass got pass=%b cnt=%0d fail=%b want 1 8 0", pass, match_cnt, fail); end
    pulse_start();
    checks++; if (pass !== 1'b0 || match_cnt !== 4'd0 || exp_ready !== 1'b1 || cycle_cnt !== 0) begin errors++;
      $display("FAIL restart_clear got pass=%b cnt=%0d rdy=%b cyc=%0d want 0 0 1 0", pass, match_cnt, exp_ready, cycle_cnt); end
    fill8(1'b0); pulse_start(); store(104, 2);
    checks++; if (fail !== 1'b1 || err_addr !== 32'd104) begin errors++;
      $display("FAIL order_fail got fail=%b ea=%0d want 1 104", fail, err_addr); end
    pulse_start();
    checks++; if (exp_ready !== 1'b1 || {pass, fail, done} !== 3'b000 || err_addr !== 0) begin errors++;
      $display("FAIL flush_idle got rdy=%b flags=%b ea=%0d want 1 000 0", exp_ready, {pass, fail, done}, err_addr); end
    pulse_start();
    checks++; if (pass !== 1'b1) begin errors++;
      $display("FAIL empty_start got pass=%b want 1", pass); end
  endtask

  task automatic test_timeout();
    do_reset(); push(84, 7); pulse_start();
    for (int i = 0; i < 19; i++) tick();
    checks++; if (timeout !== 1'b0 || cycle_cnt !== 32'd19) begin errors++;
      $display("FAIL pre_timeout got tmo=%b cyc=%0d want 0 19", timeout, cycle_cnt); end
    tick();
    checks++; if ({timeout, done, pass} !== 3'b110 || cycle_cnt !== 32'd19) begin errors++;
      $display("FAIL timeout got tmo=%b done=%b pass=%b cyc=%0d want 1 1 0 19", timeout, done, pass, cycle_cnt); end
    do_reset(); push(84, 7); pulse_start();
    for (int i = 0; i < 19; i++) tick();
    store(84, 7);
    checks++; if ({pass, timeout} !== 2'b10) begin errors++;
      $display("FAIL pass_vs_tmo got pass=%b tmo=%b want 1 0", pass, timeout); end
    do_reset(); push(84, 7); pulse_start();
    for (int i = 0; i < 19; i++) tick();
    store(90, 1);
    checks++; if ({fail, timeout} !== 2'b10) begin errors++;
      $display("FAIL fail_vs_tmo got fail=%b tmo=%b want 1 0", fail, timeout); end
  endtask

  task automatic test_reset_midrun();
    do_reset(); push(84, 7); push(88, 8); pulse_start(); store(84, 7); tick();
    reset = 1'b0; #1;
    checks++; if ({pass, fail, timeout, done} !== 4'b0 || match_cnt !== 0 || cycle_cnt !== 0 || exp_ready !== 1'b1) begin errors++;
      $display("FAIL midrun_reset got flags=%b cnt=%0d cyc=%0d rdy=%b want 0 0 0 1", {pass, fail, timeout, done}, match_cnt, cycle_cnt, exp_ready); end
    reset = 1'b1; tick();
  endtask

  task automatic test_back_to_back();
    // memwrite in IDLE and start in RUN are both ignored; push coinciding with start joins the run
    do_reset(); push(84, 7);
    store(99, 9);
    checks++; if (fail !== 1'b0 || exp_ready !== 1'b1) begin errors++;
      $display("FAIL idle_store got fail=%b rdy=%b want 0 1", fail, exp_ready); end
    exp_valid = 1'b1; exp_addr = 88; exp_data = 8; start = 1'b1; tick();
    exp_valid = 1'b0; start = 1'b0;
    store(84, 7);
    pulse_start();
    checks++; if ({pass, fail} !== 2'b00 || match_cnt !== 4'd1 || cycle_cnt !== 32'd2) begin errors++;
      $display("FAIL run_start got pass=%b fail=%b cnt=%0d cyc=%0d want 0 0 1 2", pass, fail, match_cnt, cycle_cnt); end
    store(88, 8);
    checks++; if (pass !== 1'b1 || match_cnt !== 4'd2) begin errors++;
      $display("FAIL coincide_push got pass=%b cnt=%0d want 1 2", pass, match_cnt); end
  endtask

  initial begin
    test_reset();
    test_ignore_then_match();
    test_bad_store();
    test_full_fifo();
    test_timeout();
    test_reset_midrun();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
